// File: rtl/dram_pkg.sv
// Shared DRAM controller types and default JEDEC-style timing constants.
// Imported by the command FSM interface and the timing control block.
package dram_pkg;

    typedef enum logic [2:0] {
        POWER_UP,
        IDLE,
        ACTIVATE,
        READ,
        WRITE,
        PRECHARGE,
        REFRESH
    } dram_state_t;

    localparam int TIMER_W = 12;

    localparam int DEF_T_RCD  = 14;
    localparam int DEF_T_RD   = 18;
    localparam int DEF_T_WR   = 28;
    localparam int DEF_T_RP   = 14;
    localparam int DEF_T_RFC  = 128;
    localparam int DEF_T_REFI = 3900;

    typedef struct packed {
        logic t_ref;
        logic t_pre;
        logic t_wr;
        logic t_rd;
        logic t_act;
    } done_vec_t;

    // eff counts from 0 on the entry cycle, so residency cycle T sees eff == T-1.
    function automatic logic timing_hit(input logic [TIMER_W-1:0] eff, input int t_cycles);
        return eff == TIMER_W'(t_cycles - 1);
    endfunction

endpackage

// File: rtl/command_fsm_if.sv
// Link between the command FSM (master) and the timing control block (slave).
// Carries the current command state out and the timing/refresh status back.
interface command_fsm_if;
    import dram_pkg::*;

    dram_state_t cmd_state;
    logic        tACT_done;
    logic        tRD_done;
    logic        tWR_done;
    logic        tPRE_done;
    logic        tREF_done;
    logic        rf_req;

    modport command_fsm (
        output cmd_state,
        input  tACT_done,
        input  tRD_done,
        input  tWR_done,
        input  tPRE_done,
        input  tREF_done,
        input  rf_req
    );

    modport timing_ctrl (
        input  cmd_state,
        output tACT_done,
        output tRD_done,
        output tWR_done,
        output tPRE_done,
        output tREF_done,
        output rf_req
    );

endinterface

// File: rtl/refresh_timer.sv
// Refresh interval counter: raises a sticky refresh request every T_REFI
// active cycles, cleared (with the interval restarted) on REFRESH entry.
module refresh_timer
    import dram_pkg::*;
#(
    parameter int T_REFI = DEF_T_REFI
) (
    input  logic CLK,
    input  logic nRST,
    input  logic i_active,
    input  logic i_restart,
    output logic o_rf_req
);

    localparam int REFI_W = (T_REFI > 1) ? $clog2(T_REFI) : 1;

    logic [REFI_W-1:0] r_refi;
    logic              r_rf_req;
    logic              w_expire;

    assign w_expire = (r_refi == REFI_W'(T_REFI - 1));

    // A REFRESH entry outranks a coinciding expiry, so no request is raised then.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_refi   <= '0;
            r_rf_req <= 1'b0;
        end else if (i_restart) begin
            r_refi   <= '0;
            r_rf_req <= 1'b0;
        end else if (!i_active) begin
            r_refi   <= '0;
        end else if (w_expire) begin
            r_refi   <= '0;
            r_rf_req <= 1'b1;
        end else begin
            r_refi   <= r_refi + 1'b1;
        end
    end

    assign o_rf_req = r_rf_req;

endmodule

// File: rtl/timing_control.sv
// Residency timer for the DRAM command FSM: pulses a done flag once per state
// visit when the state's minimum residency is met, and hosts the refresh timer.
module timing_control
    import dram_pkg::*;
#(
    parameter int T_RCD  = DEF_T_RCD,
    parameter int T_RD   = DEF_T_RD,
    parameter int T_WR   = DEF_T_WR,
    parameter int T_RP   = DEF_T_RP,
    parameter int T_RFC  = DEF_T_RFC,
    parameter int T_REFI = DEF_T_REFI
) (
    input  logic                      CLK,
    input  logic                      nRST,
    command_fsm_if.timing_ctrl        bus
);

    dram_state_t          r_prev_state;
    logic [TIMER_W-1:0]   r_elapsed;
    logic [TIMER_W-1:0]   w_eff;
    logic [TIMER_W-1:0]   w_elapsed_next;
    logic                 w_entry;
    logic                 w_refi_active;
    logic                 w_refresh_entry;
    done_vec_t            w_done;

    assign w_entry        = (bus.cmd_state != r_prev_state);
    assign w_eff          = w_entry ? '0 : r_elapsed;
    assign w_elapsed_next = (&w_eff) ? w_eff : w_eff + 1'b1;

    // Resetting prev_state to POWER_UP forces a fresh entry after reset.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_prev_state <= POWER_UP;
            r_elapsed    <= '0;
        end else begin
            r_prev_state <= bus.cmd_state;
            r_elapsed    <= w_elapsed_next;
        end
    end

    always_comb begin
        w_done = '0;
        case (bus.cmd_state)
            ACTIVATE:  w_done.t_act = timing_hit(w_eff, T_RCD);
            READ:      w_done.t_rd  = timing_hit(w_eff, T_RD);
            WRITE:     w_done.t_wr  = timing_hit(w_eff, T_WR);
            PRECHARGE: w_done.t_pre = timing_hit(w_eff, T_RP);
            REFRESH:   w_done.t_ref = timing_hit(w_eff, T_RFC);
            default:   w_done = '0;
        endcase
    end

    assign bus.tACT_done = w_done.t_act;
    assign bus.tRD_done  = w_done.t_rd;
    assign bus.tWR_done  = w_done.t_wr;
    assign bus.tPRE_done = w_done.t_pre;
    assign bus.tREF_done = w_done.t_ref;

    assign w_refi_active   = (bus.cmd_state != POWER_UP);
    assign w_refresh_entry = (bus.cmd_state == REFRESH) && w_entry;

    refresh_timer #(
        .T_REFI (T_REFI)
    ) u_refresh_timer (
        .CLK       (CLK),
        .nRST      (nRST),
        .i_active  (w_refi_active),
        .i_restart (w_refresh_entry),
        .o_rf_req  (bus.rf_req)
    );

endmodule

// File: tb/tb_timing_control.sv
// Self-checking bench for timing_control: per-cycle visit/refresh model plus
// directed scenarios with hand-computed cycle expectations.
module tb_timing_control;
    import dram_pkg::*;

    localparam int T_RCD  = 14;
    localparam int T_RD   = 18;
    localparam int T_WR   = 28;
    localparam int T_RP   = 1;
    localparam int T_RFC  = 128;
    localparam int T_REFI = 64;

    logic CLK = 1'b0;
    logic nRST;
    logic checkEnable = 1'b0;

    int checks   = 0;
    int failures = 0;

    command_fsm_if bus();

    timing_control #(
        .T_RCD  (T_RCD),
        .T_RD   (T_RD),
        .T_WR   (T_WR),
        .T_RP   (T_RP),
        .T_RFC  (T_RFC),
        .T_REFI (T_REFI)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int residencyFor(input dram_state_t s);
        case (s)
            ACTIVATE:  return T_RCD;
            READ:      return T_RD;
            WRITE:     return T_WR;
            PRECHARGE: return T_RP;
            REFRESH:   return T_RFC;
            default:   return 0;
        endcase
    endfunction

    // Bit order {tREF, tPRE, tWR, tRD, tACT}.
    function automatic logic [4:0] doneMask(input dram_state_t s);
        case (s)
            ACTIVATE:  return 5'b00001;
            READ:      return 5'b00010;
            WRITE:     return 5'b00100;
            PRECHARGE: return 5'b01000;
            REFRESH:   return 5'b10000;
            default:   return 5'b00000;
        endcase
    endfunction

    dram_state_t mPrev    = POWER_UP;
    int          mVisit   = 0;
    int          mActive  = 0;
    logic        mRfReq   = 1'b0;
    logic [4:0]  mObs;
    logic [4:0]  mExpDone;
    logic        mEntry;
    int          mCurLen;

    // Model: length of the current state visit and active cycles since the
    // last interval restart, checked against the outputs every cycle.
    always @(negedge CLK) begin
        if (checkEnable) begin
            mObs     = {bus.tREF_done, bus.tPRE_done, bus.tWR_done, bus.tRD_done, bus.tACT_done};
            mEntry   = (bus.cmd_state != mPrev);
            mCurLen  = mEntry ? 1 : mVisit + 1;
            mExpDone = (residencyFor(bus.cmd_state) == mCurLen) ? doneMask(bus.cmd_state) : 5'b00000;
            checkOutput("model done vector", {27'd0, mObs}, {27'd0, mExpDone});
            checkOutput("model rf_req", {31'd0, bus.rf_req}, {31'd0, mRfReq});
            checkOutput("done onehot0", {31'd0, $onehot0(mObs)}, 32'd1);
            if (!nRST) begin
                mPrev   = POWER_UP;
                mVisit  = 0;
                mActive = 0;
                mRfReq  = 1'b0;
            end else begin
                mPrev  = bus.cmd_state;
                mVisit = mCurLen;
                if (bus.cmd_state == REFRESH && mEntry) begin
                    mActive = 0;
                    mRfReq  = 1'b0;
                end else if (bus.cmd_state == POWER_UP) begin
                    mActive = 0;
                end else begin
                    mActive++;
                    if (mActive == T_REFI) begin
                        mActive = 0;
                        mRfReq  = 1'b1;
                    end
                end
            end
        end
    end

    logic [4:0] doneLog [1:256];
    logic       rfLog   [1:256];

    task automatic applyStimulus(input dram_state_t st, input int n, input logic rstN = 1'b1);
        for (int i = 1; i <= n; i++) begin
            @(posedge CLK);
            #1;
            nRST          = rstN;
            bus.cmd_state = st;
            @(negedge CLK);
            doneLog[i] = {bus.tREF_done, bus.tPRE_done, bus.tWR_done, bus.tRD_done, bus.tACT_done};
            rfLog[i]   = bus.rf_req;
        end
    endtask

    int ones;

    initial begin
        bus.cmd_state = POWER_UP;
        nRST          = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        checkEnable = 1'b1;

        applyStimulus(POWER_UP, 2, 1'b0);
        checkOutput("reset rf_req", {31'd0, rfLog[2]}, 32'd0);
        checkOutput("reset done", {27'd0, doneLog[2]}, 32'd0);
        applyStimulus(POWER_UP, 3);

        // Refresh request after 64 idle cycles, cleared by REFRESH entry.
        applyStimulus(IDLE, 95);
        checkOutput("rf_req idle c64", {31'd0, rfLog[64]}, 32'd0);
        checkOutput("rf_req idle c65", {31'd0, rfLog[65]}, 32'd1);
        checkOutput("rf_req idle c80", {31'd0, rfLog[80]}, 32'd1);
        checkOutput("rf_req idle c95", {31'd0, rfLog[95]}, 32'd1);
        applyStimulus(REFRESH, 130);
        checkOutput("rf_req refresh c1", {31'd0, rfLog[1]}, 32'd1);
        checkOutput("rf_req refresh c2", {31'd0, rfLog[2]}, 32'd0);
        checkOutput("tREF_done c127", {27'd0, doneLog[127]}, 32'd0);
        checkOutput("tREF_done c128", {27'd0, doneLog[128]}, 32'h10);
        checkOutput("tREF_done c129", {27'd0, doneLog[129]}, 32'd0);

        // Activate held 20 cycles.
        applyStimulus(IDLE, 2);
        applyStimulus(ACTIVATE, 20);
        for (int i = 1; i <= 20; i++)
            checkOutput($sformatf("tACT_done c%0d", i), {27'd0, doneLog[i]}, (i == 14) ? 32'h01 : 32'h00);

        // Aborted READ visit then a full one.
        applyStimulus(READ, 9);
        ones = 0;
        for (int i = 1; i <= 9; i++) ones += int'(doneLog[i] != 5'b0);
        checkOutput("aborted read pulses", ones, 32'd0);
        applyStimulus(IDLE, 1);
        applyStimulus(READ, 20);
        checkOutput("tRD_done c17", {27'd0, doneLog[17]}, 32'd0);
        checkOutput("tRD_done c18", {27'd0, doneLog[18]}, 32'h02);
        checkOutput("tRD_done c19", {27'd0, doneLog[19]}, 32'd0);

        // Reset in WRITE cycle 20; residency restarts after reset.
        applyStimulus(WRITE, 19);
        applyStimulus(WRITE, 1, 1'b0);
        applyStimulus(WRITE, 30);
        checkOutput("rf_req after reset", {31'd0, rfLog[1]}, 32'd0);
        checkOutput("tWR_done orig c28", {27'd0, doneLog[8]}, 32'd0);
        checkOutput("tWR_done post c27", {27'd0, doneLog[27]}, 32'd0);
        checkOutput("tWR_done post c28", {27'd0, doneLog[28]}, 32'h04);

        // REFRESH entry on the exact expiry cycle.
        applyStimulus(POWER_UP, 2);
        applyStimulus(IDLE, 63);
        checkOutput("rf_req idle c63", {31'd0, rfLog[63]}, 32'd0);
        applyStimulus(REFRESH, 70);
        ones = 0;
        for (int i = 1; i <= 65; i++) ones += int'(rfLog[i]);
        checkOutput("rf_req coincident expiry", ones, 32'd0);
        checkOutput("rf_req refresh c66", {31'd0, rfLog[66]}, 32'd1);

        // T_RP = 1: done in the entry cycle, once per visit.
        applyStimulus(IDLE, 1);
        applyStimulus(PRECHARGE, 3);
        checkOutput("tPRE_done c1", {27'd0, doneLog[1]}, 32'h08);
        checkOutput("tPRE_done c2", {27'd0, doneLog[2]}, 32'd0);
        checkOutput("tPRE_done c3", {27'd0, doneLog[3]}, 32'd0);
        applyStimulus(ACTIVATE, 1);
        applyStimulus(PRECHARGE, 1);
        checkOutput("tPRE_done reentry", {27'd0, doneLog[1]}, 32'h08);
        applyStimulus(IDLE, 2);

        @(posedge CLK);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/timing_control.md
TIMING_CONTROL -- requirements
Module: timing_control

Interface
REQ-001 Parameters (name, default, meaning); each SHALL be >=1:
- T_RCD, 14, ACTIVATE residency cycles before tACT_done
- T_RD, 18, READ residency (CL+burst) before tRD_done
- T_WR, 28, WRITE residency (CWL+burst+tWR) before tWR_done
- T_RP, 14, PRECHARGE residency before tPRE_done
- T_RFC, 128, REFRESH residency before tREF_done
- T_REFI, 3900, cycles between refresh requests
REQ-002 Ports (name, direction, width, meaning):
- CLK, in, 1, sole clock
- nRST, in, 1, synchronous active-low reset
- cmd_state, in, dram_state_t, current command FSM state
- tACT_done, out, 1, activate timing met
- tRD_done, out, 1, read timing met
- tWR_done, out, 1, write timing met
- tPRE_done, out, 1, precharge timing met
- tREF_done, out, 1, refresh timing met
- rf_req, out, 1, refresh due
REQ-003 One clock; reset is synchronous and active-low. Clock port is CLK; reset port is nRST.

Function
REQ-004 prev_state register SHALL capture cmd_state every cycle. entry = (cmd_state != prev_state).
REQ-005 elapsed register (TIMER_W bits). eff = entry ? 0 : elapsed. elapsed_next = eff+1, saturating at all-ones.
REQ-006 Each done output is combinational. Example: tACT_done = (cmd_state==ACTIVATE) && (eff==T_RCD-1). READ, WRITE, PRECHARGE and REFRESH use T_RD, T_WR, T_RP and T_RFC in the same way.
REQ-007 The entry cycle is residency cycle 1, so done asserts in cycle T of residency. T=1 asserts done in the entry cycle.
REQ-008 Each done is a single-cycle pulse per state visit. If cmd_state stays after the pulse, done stays low.
REQ-009 If cmd_state leaves before cycle T, that timing is aborted and no done asserts. A later entry restarts from 0.
REQ-010 At most one done output is high in any cycle. All done outputs are low in states without a timing parameter.
REQ-011 refi counter counts cycles while cmd_state != POWER_UP, and holds 0 during POWER_UP.
REQ-012 When refi reaches T_REFI-1: rf_req sets (registered, visible next cycle) and refi wraps to 0.
REQ-013 rf_req is sticky until a cycle where cmd_state==REFRESH && entry. rf_req is low from the following cycle, and refi restarts from 0 that same cycle.
REQ-014 If refi expiry coincides with REFRESH entry, the REFRESH entry wins: rf_req is not set and refi is 0.
REQ-015 Expiry while rf_req is already high leaves rf_req high. No request counting or postponement tracking.

Reset
REQ-016 With nRST low at a rising edge: prev_state=POWER_UP, elapsed=0, refi=0, rf_req=0.
REQ-017 Reset mid-residency: the next timing restarts from the entry after reset. Done outputs SHALL NOT pulse from pre-reset counts.
REQ-018 The combinational done outputs are low while cmd_state is POWER_UP or IDLE, including after reset.

Structure
REQ-019 dram_pkg SHALL hold:
- dram_state_t, with at least POWER_UP, IDLE, ACTIVATE, READ, WRITE, PRECHARGE, REFRESH
- TIMER_W = 12
- default timing constants
REQ-020 The block SHALL connect to command_fsm_if via the timing_ctrl modport, extended with the done and rf_req outputs.
REQ-021 The optional sub-module is refresh_timer (refi counter plus rf_req). The residency counter stays in timing_control.

Verification (bench overrides T_REFI=64)
REQ-022 IDLE -> ACTIVATE held 20 cycles -> tACT_done high in cycle 14 only, low in cycles 1-13 and 15-20.
REQ-023 READ entered, leaves to IDLE at cycle 10, re-enters READ -> no tRD_done in the first visit; tRD_done in cycle 18 of the second visit.
REQ-024 Leave POWER_UP, stay IDLE -> rf_req rises on cycle 65, stays high 30 more cycles; REFRESH entry -> rf_req low next cycle; tREF_done in REFRESH cycle 128.
REQ-025 Drive REFRESH entry exactly on the refi expiry cycle -> rf_req never rises; next rf_req 64 cycles later.
REQ-026 nRST low for 1 cycle at WRITE cycle 20, WRITE held -> no tWR_done at the original cycle 28; rf_req=0 after reset.
REQ-027 PRECHARGE with T_RP=1 override -> tPRE_done in the entry cycle; assertion: done outputs are never simultaneously high.
